// File: rtl/sram_req_arbiter_pkg.sv
// Shared types for the instruction/data SRAM request arbiter.
package sram_req_arbiter_pkg;

  // Requester identity; also the payload stored in the in-order tag FIFO.
  typedef enum logic {
    ArbSrcInst = 1'b0,
    ArbSrcData = 1'b1
  } arb_src_e;

  // Address-phase FSM: StHold means a grant is on the bus but not yet accepted.
  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } arb_state_e;

  // Unified request bus: wr + wstrb + addr + wdata (69 bits) plus source (1 bit).
  localparam int unsigned ArbReqBusWd = 70;

  typedef struct packed {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    arb_src_e    src;
  } arb_req_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of 1-bit source tags for outstanding memory transactions.
module arb_tag_fifo #(
  parameter int unsigned Depth = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic head,
  output logic full,
  output logic empty
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int unsigned PtrW = $clog2(Depth) + 1;
  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0]  ptr_diff;
  logic [IdxW-1:0]  wr_idx, rd_idx;

  // Storage index and occupancy derived from the wrap-bit pointers.
  always_comb begin
    wr_idx   = (Depth > 1) ? wr_ptr_q[IdxW-1:0] : '0;
    rd_idx   = (Depth > 1) ? rd_ptr_q[IdxW-1:0] : '0;
    ptr_diff = wr_ptr_q - rd_ptr_q;
    full     = (ptr_diff == PtrW'(Depth));
    empty    = (wr_ptr_q == rd_ptr_q);
    head     = mem_q[rd_idx];
  end

  // Pointer advance and tag write; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_idx] <= din;
        wr_ptr_q      <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Arbitrates the fetch and data ports onto one split-transaction memory port,
// holding each grant until accepted and routing responses back in issue order.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned OUTSTANDING  = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  arb_state_e      state_q;
  arb_src_e        grant_src_q;
  logic [CntW-1:0] starve_q;
  logic            arb_err_q;

  logic     fifo_full_raw, fifo_empty, fifo_head;
  logic     fifo_full, push, pop, starved;
  arb_src_e idle_src, grant;
  arb_req_t inst_bus, data_bus, sel_bus;

  arb_tag_fifo #(
    .Depth(OUTSTANDING)
  ) u_tag_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (grant),
    .head (fifo_head),
    .full (fifo_full_raw),
    .empty(fifo_empty)
  );

  // Grant selection, request muxing and handshake routing (zero added latency).
  always_comb begin
    pop       = mem_data_ok & ~fifo_empty & ~reset;
    // A same-cycle pop frees a slot, so fullness is judged after the pop.
    fifo_full = fifo_full_raw & ~pop;
    starved   = (starve_q == CntW'(STARVE_LIMIT)) & inst_req;
    idle_src  = (data_req & ~starved) ? ArbSrcData : ArbSrcInst;
    grant     = (state_q == StHold) ? grant_src_q : idle_src;

    inst_bus  = '{wr: 1'b0, wstrb: 4'h0, addr: inst_addr, wdata: 32'h0, src: ArbSrcInst};
    data_bus  = '{wr: data_wr, wstrb: data_wstrb, addr: data_addr, wdata: data_wdata,
                  src: ArbSrcData};
    sel_bus   = (grant == ArbSrcData) ? data_bus : inst_bus;

    mem_req   = ~reset & ~fifo_full & (inst_req | data_req | (state_q == StHold));
    mem_wr    = sel_bus.wr;
    mem_wstrb = sel_bus.wstrb;
    mem_addr  = sel_bus.addr;
    mem_wdata = sel_bus.wdata;

    push         = mem_req & mem_addr_ok;
    inst_addr_ok = push & (sel_bus.src == ArbSrcInst);
    data_addr_ok = push & (sel_bus.src == ArbSrcData);

    inst_data_ok = pop & (arb_src_e'(fifo_head) == ArbSrcInst);
    data_data_ok = pop & (arb_src_e'(fifo_head) == ArbSrcData);
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
    arb_err      = arb_err_q;
  end

  // Address-phase FSM: latch the source whenever a presented grant is not accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_src_q <= ArbSrcInst;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_req && !mem_addr_ok) begin
            state_q     <= StHold;
            grant_src_q <= grant;
          end
        end
        StHold: begin
          if (mem_addr_ok) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Starvation counter: counts consecutive cycles the fetch request is denied.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else if (!inst_req || inst_addr_ok) begin
      starve_q <= '0;
    end else if (starve_q != CntW'(STARVE_LIMIT)) begin
      starve_q <= starve_q + CntW'(1);
    end
  end

  // Sticky error: a response arrived with nothing outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      arb_err_q <= 1'b0;
    end else if (mem_data_ok && fifo_empty) begin
      arb_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed and randomized bench for sram_req_arbiter against a queue-based model.
module tb_sram_req_arbiter;

  localparam int Outst = 2;
  localparam int Limit = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        arb_err;

  int checks = 0;
  int failures = 0;

  // Reference model state: outstanding sources in issue order (0 inst, 1 data).
  int q[$];
  int held = -1;
  int starve = 0;
  bit err = 1'b0;

  always #5 clk = ~clk;

  sram_req_arbiter #(
    .OUTSTANDING (Outst),
    .STARVE_LIMIT(Limit)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_wstrb  (data_wstrb),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_wstrb   (mem_wstrb),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata),
    .arb_err     (arb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Compare every output with the model for the current inputs, then clock and update.
  task automatic cycle_chk(input string tag);
    int  src;
    bit  full, mreq, pop, acc, mdo, ireq;
    #1;
    mdo  = mem_data_ok;
    ireq = inst_req;
    pop  = !reset && mdo && q.size() > 0;
    full = (q.size() >= Outst) && !pop;
    if (held >= 0) src = held;
    else if (data_req && !(starve >= Limit && inst_req)) src = 1;
    else if (inst_req) src = 0;
    else src = -1;
    mreq = !reset && src >= 0 && !full;
    acc  = mreq && mem_addr_ok;

    check({tag, ":mem_req"}, 32'(mem_req), 32'(mreq));
    if (mreq && src == 1) begin
      check({tag, ":mem_addr"}, mem_addr, data_addr);
      check({tag, ":mem_wr"}, 32'(mem_wr), 32'(data_wr));
      check({tag, ":mem_wstrb"}, 32'(mem_wstrb), 32'(data_wstrb));
      check({tag, ":mem_wdata"}, mem_wdata, data_wdata);
    end else if (mreq) begin
      check({tag, ":mem_addr"}, mem_addr, inst_addr);
      check({tag, ":mem_wr"}, 32'(mem_wr), 32'd0);
      check({tag, ":mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    end
    check({tag, ":inst_addr_ok"}, 32'(inst_addr_ok), 32'(acc && src == 0));
    check({tag, ":data_addr_ok"}, 32'(data_addr_ok), 32'(acc && src == 1));
    check({tag, ":inst_data_ok"}, 32'(inst_data_ok), 32'(pop && q[0] == 0));
    check({tag, ":data_data_ok"}, 32'(data_data_ok), 32'(pop && q[0] == 1));
    if (pop) begin
      check({tag, ":inst_rdata"}, inst_rdata, mem_rdata);
      check({tag, ":data_rdata"}, data_rdata, mem_rdata);
    end
    check({tag, ":arb_err"}, 32'(arb_err), 32'(err));

    @(posedge clk);
    if (reset) begin
      q.delete();
      held   = -1;
      starve = 0;
      err    = 1'b0;
    end else begin
      if (mdo && q.size() == 0) err = 1'b1;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(src);
      if (mreq && !acc) held = src;
      else if (acc) held = -1;
      if (ireq && !(acc && src == 0)) starve = (starve < Limit) ? starve + 1 : Limit;
      else starve = 0;
    end
    #1;
  endtask

  task automatic quiet_inputs();
    inst_req    = 1'b0;
    inst_addr   = 32'h0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_wstrb  = 4'h0;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
  endtask

  initial begin
    quiet_inputs();

    // Reset with both requests high: nothing may handshake.
    reset = 1'b1; inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    inst_addr = 32'h1C00_0000; data_addr = 32'h1C00_0100; data_wr = 1'b1;
    data_wstrb = 4'hF; data_wdata = 32'h1234_5678;
    #1;
    check("rst:mem_req", 32'(mem_req), 32'd0);
    check("rst:inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    check("rst:data_addr_ok", 32'(data_addr_ok), 32'd0);
    check("rst:data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    check("rst:arb_err", 32'(arb_err), 32'd0);
    cycle_chk("rst0");
    cycle_chk("rst1");

    // Release: data has priority in the very first cycle.
    reset = 1'b0; mem_data_ok = 1'b0;
    #1;
    check("prio:mem_addr", mem_addr, 32'h1C00_0100);
    check("prio:data_addr_ok", 32'(data_addr_ok), 32'd1);
    check("prio:inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    cycle_chk("prio");
    inst_req = 1'b0; data_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_0001;
    cycle_chk("drain0");

    // Hold: inst grant not accepted for 3 cycles while data_req rises.
    mem_data_ok = 1'b0; inst_req = 1'b1; mem_addr_ok = 1'b0; data_wr = 1'b0;
    cycle_chk("hold0");
    data_req = 1'b1; data_addr = 32'h1C00_0200;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("hold:mem_addr", mem_addr, 32'h1C00_0000);
      cycle_chk("hold");
    end
    mem_addr_ok = 1'b1;
    #1;
    check("hold:accept_addr", mem_addr, 32'h1C00_0000);
    check("hold:inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    cycle_chk("hold_acc");

    // Ordering: data accepted behind inst, responses routed in issue order.
    inst_req = 1'b0;
    #1;
    check("order:data_addr_ok", 32'(data_addr_ok), 32'd1);
    cycle_chk("order_acc");
    data_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hAAAA_0000;
    #1;
    check("order:inst_data_ok", 32'(inst_data_ok), 32'd1);
    check("order:inst_rdata", inst_rdata, 32'hAAAA_0000);
    check("order:data_data_ok0", 32'(data_data_ok), 32'd0);
    cycle_chk("order_r0");
    mem_rdata = 32'h5555_FFFF;
    #1;
    check("order:data_data_ok", 32'(data_data_ok), 32'd1);
    check("order:data_rdata", data_rdata, 32'h5555_FFFF);
    check("order:inst_data_ok1", 32'(inst_data_ok), 32'd0);
    cycle_chk("order_r1");

    // Full FIFO: two outstanding blocks mem_req; pop+push together keeps count at 2.
    mem_data_ok = 1'b0; data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h1C00_0300;
    cycle_chk("full_a0");
    cycle_chk("full_a1");
    #1;
    check("full:mem_req", 32'(mem_req), 32'd0);
    check("full:data_addr_ok", 32'(data_addr_ok), 32'd0);
    cycle_chk("full_blk");
    mem_data_ok = 1'b1;
    #1;
    check("full:pp_mem_req", 32'(mem_req), 32'd1);
    check("full:pp_addr_ok", 32'(data_addr_ok), 32'd1);
    check("full:pp_data_ok", 32'(data_data_ok), 32'd1);
    cycle_chk("full_pp");
    mem_data_ok = 1'b0;
    #1;
    check("full:still_full", 32'(mem_req), 32'd0);
    cycle_chk("full_blk2");
    data_req = 1'b0; mem_data_ok = 1'b1;
    cycle_chk("full_d0");
    cycle_chk("full_d1");

    // Starvation: inst wins after exactly 8 denied cycles.
    mem_data_ok = 1'b0;
    cycle_chk("starve_idle");
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0;
    for (int i = 0; i < Limit; i++) begin
      #1;
      check("starve:data_addr_ok", 32'(data_addr_ok), 32'd1);
      check("starve:inst_addr_ok", 32'(inst_addr_ok), 32'd0);
      cycle_chk("starve");
      mem_data_ok = 1'b1;
    end
    #1;
    check("starve:inst_wins", 32'(inst_addr_ok), 32'd1);
    check("starve:data_denied", 32'(data_addr_ok), 32'd0);
    cycle_chk("starve_win");
    inst_req = 1'b0; data_req = 1'b0;
    cycle_chk("starve_drain");

    // Response with nothing outstanding: dropped, sticky error.
    #1;
    check("err:inst_data_ok", 32'(inst_data_ok), 32'd0);
    check("err:data_data_ok", 32'(data_data_ok), 32'd0);
    cycle_chk("err0");
    mem_data_ok = 1'b0;
    #1;
    check("err:set", 32'(arb_err), 32'd1);
    cycle_chk("err1");
    cycle_chk("err2");
    check("err:sticky", 32'(arb_err), 32'd1);

    reset = 1'b1;
    cycle_chk("rst2");
    reset = 1'b0;

    // Randomized traffic; a held requester keeps its request stable.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      if (held != 0) begin
        inst_req  = ($urandom_range(0, 3) != 0);
        inst_addr = $urandom;
      end
      if (held != 1) begin
        data_req   = ($urandom_range(0, 3) != 0);
        data_wr    = $urandom_range(0, 1);
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(0, 2) != 0);
      mem_data_ok = (q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      mem_rdata   = $urandom;
      cycle_chk("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Shares a single unified memory request port between the instruction-fetch port and the data-access port of the CPU. Both sides use a req/addr_ok/data_ok split-transaction handshake, and responses return in issue order. The block picks one requester per address phase and holds the pick until the memory accepts it. It tracks outstanding transactions in a small in-order tag FIFO and routes each `mem_data_ok` back to the requester that issued it. It sits between the IF/MEM stages and the memory-side bridge.

## Interface
- `OUTSTANDING`, 2: max accepted-but-unanswered transactions (power of 2, ≥1)
- `STARVE_LIMIT`, 8: consecutive denied cycles after which the inst request wins
- `clk`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `inst_req` / `inst_addr`  in  1/32  fetch request (read-only)
- `inst_addr_ok` / `inst_data_ok`  out  1/1  fetch accepted / fetch data valid
- `inst_rdata`  out  32  fetch data
- `data_req` / `data_wr` / `data_wstrb`  in  1/1/4  data request, write flag, byte strobes
- `data_addr` / `data_wdata`  in  32/32  data address / write data
- `data_addr_ok` / `data_data_ok`  out  1/1  data accepted / response (read data or write ack)
- `data_rdata`  out  32  load data
- `mem_req` / `mem_wr` / `mem_wstrb`  out  1/1/4  unified request
- `mem_addr` / `mem_wdata`  out  32/32  unified address / write data
- `mem_addr_ok` / `mem_data_ok`  in  1/1  memory accept / response
- `mem_rdata`  in  32  memory read data
- `arb_err`  out  1  sticky flag: `mem_data_ok` arrived with no outstanding transaction

## Operation
- States: `IDLE` (no held grant) and `HOLD` (a grant was presented and not yet accepted; `grant_src` is latched).
- In `IDLE` with `fifo_full`=0:
  - If `data_req`, grant data. Exception: if `starve_cnt`==`STARVE_LIMIT` and `inst_req`=1, grant inst.
  - Else if `inst_req`, grant inst.
- In `HOLD`: keep the latched source.
  - `mem_*` fields come from the granted requester. The requester must hold its request stable until it sees addr_ok.
- Transitions:
  - `IDLE`→`HOLD` when `mem_req`=1 and `mem_addr_ok`=0.
  - `HOLD`→`IDLE` on `mem_addr_ok`=1.
  - `IDLE` stays `IDLE` if accepted in the same cycle.
- `mem_req` = (any req, or `HOLD`) and !`fifo_full`. `HOLD` and `fifo_full` cannot coexist, because entering `HOLD` requires !full.
- For inst grants, `mem_wr`=0 and `mem_wstrb`=4'h0; `mem_wdata` is don't-care.
- Handshake outputs:
  - `inst_addr_ok` = `mem_req` & `mem_addr_ok` & grant==INST.
  - `data_addr_ok` = `mem_req` & `mem_addr_ok` & grant==DATA.
- On accept, push `grant_src` into the tag FIFO. On `mem_data_ok`, pop the head and pulse the matching `*_data_ok`. `mem_rdata` is fanned out to both `*_rdata` unconditionally.
- Push and pop in the same cycle leave the count unchanged. With `OUTSTANDING`=1, a full-FIFO pop and a push in the same cycle is allowed: the pop frees the slot combinationally, so `fifo_full` is computed after pop.
- `mem_data_ok` while the FIFO is empty:
  - Drop it; no `*_data_ok` pulse.
  - Set `arb_err`, which stays set until reset.
- `starve_cnt`:
  - Increments, saturating at `STARVE_LIMIT`, in each cycle where `inst_req`=1 and `inst_addr_ok`=0.
  - Clears on `inst_addr_ok`, and in any cycle where `inst_req`=0.
- Combinational paths requester→mem and mem→requester are required. The arbiter adds zero latency.

## Timing
- Reset values:
  - State `IDLE`, FIFO empty, `starve_cnt`=0, `arb_err`=0.
  - All `*_ok` outputs and `mem_req` are 0 during the reset cycle.
- Reset mid-transaction discards held grants and outstanding tags. The memory side is reset by the same `reset`.
- Best-case latency is 0 cycles: request → `mem_req` in the same cycle, and `mem_data_ok` → `*_data_ok` in the same cycle.
- Throughput is one accept per cycle while the FIFO is not full.
- A grant never switches while `HOLD`, even if a higher-priority request appears.

## Structure
- Shared header `myCPU.h`: add `` `ARB_SRC_INST `` (1'b0), `` `ARB_SRC_DATA `` (1'b1), and `` `ARB_REQ_BUS_WD `` (70: wr, wstrb, addr, wdata, 1+4+32+32 = 69 bits, plus src, 1 bit).
- Sub-module `arb_tag_fifo`:
  - Parameterised depth, 1-bit payload.
  - Ports: push, pop, head, full, empty.
  - Circular pointers with an extra wrap bit.
- The top level holds the FSM, the starvation counter, and the muxing.

## Test plan
- **Reset:** assert `reset` with both reqs high → all `*_ok`=0, `mem_req`=0, `arb_err`=0; release → data granted in the first cycle.
- **Priority:** `inst_req` and `data_req` with `data_addr`=0x1C000100, `mem_addr_ok`=1 → `mem_addr`=0x1C000100, `data_addr_ok`=1, `inst_addr_ok`=0.
- **Hold:** inst granted (`inst_addr`=0x1C000000), `mem_addr_ok`=0 for 3 cycles while `data_req` rises → `mem_addr` stays 0x1C000000 until accept.
- **Ordering:** accept inst then data, then `mem_data_ok` twice with `mem_rdata` 0xAAAA0000, then 0x5555FFFF → `inst_data_ok` on the first response (`inst_rdata` 0xAAAA0000), `data_data_ok` on the second (`data_rdata` 0x5555FFFF).
- **Full FIFO:** 2 accepted, no response → `mem_req`=0; a `mem_data_ok` plus a new req in the same cycle → pop and push together, count stays 2.
- **Starvation and error:** `data_req` held continuously with `inst_req` → inst granted after exactly 8 denied cycles. `mem_data_ok` with the FIFO empty → `arb_err`=1 (sticky), no `*_data_ok` pulse.
